adder_driver: RTL
=================

# adder_driver

Self-contained stimulus driver and response checker for the 16-bit operand/sum interface of the `test` adder block: it drives operand buses A and B and samples sum bus C. It generates operand pairs from an LFSR, holds each pair for a fixed settle window, compares C against the modulo-2^WIDTH sum, and reports a pass/fail verdict. It sits in the `skel` harness in place of the undriven `A`/`B` registers, so a DUT can be exercised on hardware or in simulation without any VPI script.

## Interface
- WIDTH, 16, operand/sum width; legal range 1..16.
- NUM_VECTORS, 256, number of operand pairs per run; legal range 1..65535.
- SETTLE, 2, cycles A/B are held before C is sampled; minimum 1.
- SEED, 32'h0001_0002, initial LFSR state; 0 is replaced by 32'h1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  pulse; begins a run when in IDLE or DONE.
- C  in  WIDTH  sum returned by the DUT.
- A  out  WIDTH  operand A, registered.
- B  out  WIDTH  operand B, registered.
- busy  out  1  high in DRIVE, WAIT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  valid while done is high; 1 when err_count is 0.
- err_count  out  16  mismatches in the current or last run; saturates at 16'hFFFF.
- vec_count  out  16  vectors checked so far in the current or last run.

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE or DONE with start=1:
  - load LFSR with SEED;
  - clear err_count and vec_count;
  - go to DRIVE.
- DRIVE:
  - A <= lfsr[WIDTH-1:0];
  - B <= lfsr[WIDTH+15:16];
  - LFSR advances one step;
  - go to WAIT with the settle counter set to SETTLE-1.
- WAIT: decrement the settle counter; go to CHECK when it reaches 0.
- CHECK:
  - expected = (A + B) mod 2^WIDTH, so the carry out is discarded;
  - if C != expected, err_count increments, saturating at 16'hFFFF;
  - vec_count increments;
  - go to DONE if the new vec_count == NUM_VECTORS, else go to DRIVE.
- DONE: A and B hold their last values; done=1; the state holds until start is asserted.
- LFSR: 32-bit Galois, right shift, tap mask 32'h8020_0003; it never takes the value 0.
- start while busy is ignored; there is no abort.
- C is sampled only in CHECK, and its value in all other states is don't-care.
- X or Z on C counts as a mismatch. This is a simulation-only effect of the `!==` compare.

## Timing
- Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, vec_count=0; state IDLE; LFSR=SEED.
- Asserting rst_n low mid-run returns to IDLE immediately and clears all outputs. The run is discarded and does not resume.
- Each vector takes SETTLE+2 cycles: 1 DRIVE, SETTLE WAIT, 1 CHECK.
- A and B change on the clock edge that leaves DRIVE.
- C must be valid within SETTLE cycles of that edge.
- The `test` DUT responds combinationally in zero time, so SETTLE=1 suffices for it.
- Run length: done rises 1 + NUM_VECTORS*(SETTLE+2) cycles after the edge on which start is sampled.
- busy rises on the edge after start is sampled. busy falls on the same edge on which done rises.
- pass is registered together with done.

## Configuration
- ADDER_DRIVER_FAILCAP_EN defined:
  - extra outputs fail_a, fail_b, fail_c, each WIDTH bits and reset to 0;
  - they capture A, B and C at the first mismatch of a run;
  - they are cleared by start;
  - they do not update on later mismatches.
- ADDER_DRIVER_FAILCAP_EN undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Package adder_driver_pkg holds:
  - state enum adder_driver_state_t;
  - constant LFSR_TAPS = 32'h8020_0003;
  - constant LFSR_SEED_DEFAULT = 32'h0001_0002.
- Sub-module adder_driver_lfsr:
  - ports: clk, rst_n, load, seed, step, q[31:0];
  - it is the only natural split.
- FSM, counters and compare live in the top level.

## Test plan
- Correct DUT (`test`):
  - stimulus: NUM_VECTORS=4, SETTLE=2, start pulse;
  - response: done rises 17 cycles after start is sampled; pass=1, err_count=0, vec_count=4.
- Stuck-at-zero DUT:
  - stimulus: C tied to 0, SEED=32'h0001_0002, NUM_VECTORS=1;
  - response: A=2, B=1; err_count=1, pass=0.
- Wrap-around:
  - stimulus: SEED=32'h0001_FFFF, NUM_VECTORS=1, correct DUT;
  - response: A=16'hFFFF, B=16'h0001, expected=16'h0000; pass=1.
- Reset mid-run:
  - stimulus: rst_n low during vector 3 of 8;
  - response: busy=0, vec_count=0, A=0 on the same edge; a new start gives a fresh 8-vector run with pass=1.
- start while busy:
  - stimulus: second start pulse in WAIT;
  - response: no restart; vec_count reaches NUM_VECTORS exactly once.
- With ADDER_DRIVER_FAILCAP_EN:
  - stimulus: DUT whose C is A+B+1 only on vector 2;
  - response: fail_a, fail_b and fail_c hold vector 2's values; err_count=1.

Source files
------------

// File: rtl/adder_driver_pkg.sv
// ============================================================================
// Module   : adder_driver_pkg
// Brief    : Shared state encoding, LFSR constants and step function.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adder_driver_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_WAIT  = ST_WAIT,
        S_CHECK = ST_CHECK,
        S_DONE  = ST_DONE
    } adder_driver_state_t;

    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0001_0002;

    // Galois right-shift step; a nonzero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_driver_lfsr.sv
// ============================================================================
// Module   : adder_driver_lfsr
// Brief    : 32-bit Galois LFSR with seed load; an all-zero seed becomes 1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_driver_lfsr
    import adder_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] w_seed;

    assign w_seed = (seed == 32'h0) ? 32'h1 : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= w_seed;
        end else if (load) begin
            q <= w_seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_driver.sv
// ============================================================================
// Module   : adder_driver
// Brief    : LFSR operand driver and sum checker for a WIDTH-bit adder DUT.
//            Define ADDER_DRIVER_FAILCAP_EN to add first-failure capture ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder_driver
    import adder_driver_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          NUM_VECTORS = 256,
    parameter int          SETTLE      = 2,
    parameter logic [31:0] SEED        = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count
`ifdef ADDER_DRIVER_FAILCAP_EN
    ,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_c
`endif
);

    localparam logic [15:0] C_SETTLE_INIT = 16'(SETTLE - 1);
    localparam logic [15:0] C_VEC_LAST    = 16'(NUM_VECTORS);

    adder_driver_state_t state;
    logic [15:0]         settle_cnt;
    logic                start_q;
    logic [31:0]         lfsr_q;
    logic                lfsr_load;
    logic                lfsr_step;
    logic [WIDTH-1:0]    expected;
    logic                mismatch;
    logic [15:0]         err_next;
    logic [15:0]         vec_next;

    // start is registered first, so the FSM leaves IDLE/DONE one edge after sampling.
    assign lfsr_load = ((state == S_IDLE) || (state == S_DONE)) && start_q;
    assign lfsr_step = (state == S_DRIVE);

    adder_driver_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    assign expected = A + B;
    assign mismatch = (C !== expected);
    assign err_next = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
    assign vec_next = vec_count + 16'd1;
    assign busy     = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            settle_cnt <= 16'd0;
            A          <= '0;
            B          <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            vec_count  <= 16'd0;
`ifdef ADDER_DRIVER_FAILCAP_EN
            fail_a     <= '0;
            fail_b     <= '0;
            fail_c     <= '0;
`endif
        end else begin
            start_q <= start;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_q) begin
                        state     <= S_DRIVE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 16'd0;
                        vec_count <= 16'd0;
`ifdef ADDER_DRIVER_FAILCAP_EN
                        fail_a    <= '0;
                        fail_b    <= '0;
                        fail_c    <= '0;
`endif
                    end
                end
                S_DRIVE: begin
                    A          <= lfsr_q[WIDTH-1:0];
                    B          <= lfsr_q[WIDTH+15:16];
                    settle_cnt <= C_SETTLE_INIT;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (settle_cnt == 16'd0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 16'd1;
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    vec_count <= vec_next;
`ifdef ADDER_DRIVER_FAILCAP_EN
                    // err_count saturates and never returns to 0, so it marks the first failure.
                    if (mismatch && (err_count == 16'd0)) begin
                        fail_a <= A;
                        fail_b <= B;
                        fail_c <= C;
                    end
`endif
                    if (vec_next == C_VEC_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end else begin
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
